jtframe_pocket_upload: RTL and testbench
========================================

// Module: jtframe_pocket_upload
// PURPOSE
// Read-side companion of the Pocket bridge download path: serves APF bridge reads (NVRAM/save upload)
// from core memory. Fetches bytes over an ioctl-style read handshake, packs them big-endian into
// 32-bit words and keeps one word prefetched so sequential bridge reads are answered on the next cycle.
// Sits in the Pocket base between the bridge (via core clock domain) and the core memory mux.
// PARAMETERS
// AW       25   byte address width on the core side (ioctl_addr)
// TIMEOUT  255  cycles to wait for ioctl_rdy per byte before substituting 8'hFF (max 255)
// PORTS
// clk            in   1   core/ROM clock; the only clock
// rst_n          in   1   asynchronous, active-low reset
// upload_start   in   1   one-cycle pulse: start upload session at upload_base
// upload_stop    in   1   one-cycle pulse: end session (dataslot all-complete)
// upload_base    in   AW  first byte address of the session; bits [1:0] ignored
// bridge_rd      in   1   one-cycle bridge read strobe
// bridge_addr    in   32  bridge read byte address
// bridge_rd_data out  32  read data, big-endian (byte at offset 0 in [31:24])
// rd_valid       out  1   one-cycle pulse when bridge_rd_data updated for latest bridge_rd
// busy           out  1   a bridge read is outstanding (miss being serviced)
// uploading      out  1   session active
// timeout_err    out  1   sticky: some byte timed out this session
// ioctl_addr     out  AW  core byte address being read
// ioctl_rd       out  1   one-cycle read request for ioctl_addr
// ioctl_din      in   8   core read data, valid when ioctl_rdy
// ioctl_rdy      in   1   one-cycle data-valid for last ioctl_rd
// BEHAVIOUR
// - Reset (rst_n low, async): all outputs 0, buffer invalid, FSM IDLE, pending cleared. Reset
//   mid-fetch abandons the fetch; no further ioctl_rd until a new upload_start.
// - Word address waddr = bridge_addr[AW-1:2]. Reads with bridge_addr[31:24]==8'hF8 are ignored
//   entirely. bridge_rd while uploading==0 ignored.
// - Buffer: word buf[31:0], tag[AW-1:2], valid bit.
// - FSM: IDLE -> REQ (ioctl_rd=1 one cycle, ioctl_addr={ftag,bcnt}) -> WAIT (count cycles) ->
//   on ioctl_rdy or count==TIMEOUT: store byte (ioctl_din or 8'hFF, set timeout_err), bcnt++;
//   bcnt wraps 3->0 => FILL (buf<=packed word, tag<=ftag, valid<=1) -> IDLE, else -> REQ.
//   Byte n of a word goes to buf[31-8n -: 8]. Timer resets per byte.
// - upload_start: uploading<=1, timeout_err<=0, valid<=0, fetch word upload_base[AW-1:2].
// - upload_stop: uploading<=0 after current byte completes; no new fetch started.
// - bridge_rd hit (valid && tag==waddr): next cycle bridge_rd_data<=buf, rd_valid=1; then
//   prefetch tag+1 (wraps modulo 2^(AW-2)).
// - bridge_rd matching the word in flight: pending set, busy=1; at FILL data delivered
//   (bridge_rd_data, rd_valid same cycle as valid set), busy=0, prefetch next.
// - bridge_rd miss: pending set, busy=1, valid<=0; current byte finishes (never abort a core
//   handshake mid-byte), remaining bytes of that word dropped, then fetch waddr from byte 0.
// - New bridge_rd while busy: replaces pending address (latest wins), same miss rule.
// - upload_start during fetch: same as miss, current byte completes, restart at new base.
// - upload_start and bridge_rd same cycle: upload_start wins, bridge_rd dropped.
// - ioctl_rdy outside WAIT ignored. ioctl_rd never asserted twice without rdy/timeout between.
// - Latency: hit 1 cycle; miss 4*(2+core latency) cycles min.
// TESTING
// - start base 0; mem[0..3]=11,22,33,44, rdy 2 cyc after rd -> ioctl_rd at 0,1,2,3; rd addr 0 ->
//   next cycle rd_data=32'h11223344, rd_valid; then ioctl_rd at 4..7 prefetch.
// - Sequential rd 0x0,0x4,0x8 spaced 20 cycles -> each answered 1 cycle later, busy never high.
// - rd 0x100 with buffer at 0x4 -> busy=1, ioctl_rd 0x100..0x103, rd_data=mem word, busy=0.
// - TIMEOUT=15, core never rdy -> each byte after 16 cycles =FF; rd_data=32'hFFFFFFFF,
//   timeout_err=1 until next upload_start.
// - rd at 32'hF8000000 -> no ioctl_rd, no rd_valid; rd with uploading=0 -> ignored.
// - rst_n low during WAIT -> all outputs 0 same cycle; late ioctl_rdy after reset has no effect.

Source files
------------

// File: rtl/jtframe_pocket_upload.sv
// Pocket bridge upload path: answers APF bridge reads from core memory. Bytes arrive over
// an ioctl read handshake, are packed big-endian, and one word is kept prefetched.
module jtframe_pocket_upload #(
  parameter int AW      = 25,
  parameter int TIMEOUT = 255
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          upload_start,
  input  logic          upload_stop,
  input  logic [AW-1:0] upload_base,
  input  logic          bridge_rd,
  input  logic [31:0]   bridge_addr,
  output logic [31:0]   bridge_rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          uploading,
  output logic          timeout_err,
  output logic [AW-1:0] ioctl_addr,
  output logic          ioctl_rd,
  input  logic [7:0]    ioctl_din,
  input  logic          ioctl_rdy
);
  localparam int TW = AW - 2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
  state_t state, state_nx;

  logic [TW-1:0] ftag, ntag, tag, ptag, waddr, target;
  logic [1:0]    bcnt;
  logic [7:0]    cnt;
  logic [31:0]   fword, wbuf;
  logic          valid, want, pend, stop_req;
  logic          acc, hit, bdone, stop_now, fetching;
  logic          unused_bits;

  assign waddr       = bridge_addr[AW-1:2];
  assign acc         = bridge_rd && uploading && (bridge_addr[31:24] != 8'hF8);
  assign hit         = valid && (tag == waddr);
  assign bdone       = (state == WAIT) && (ioctl_rdy || (cnt == 8'(TIMEOUT)));
  assign stop_now    = stop_req || (upload_stop && !upload_start);
  // A raised 'want' means the word in flight will be abandoned in favour of ntag
  assign fetching    = (state != IDLE) || want;
  assign target      = want ? ntag : ftag;
  assign ioctl_addr  = {ftag, bcnt};
  assign busy        = pend;
  assign unused_bits = ^{bridge_addr, upload_base[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ioctl_rd = 1'b0;
    case (state)
      IDLE: if (want && uploading) state_nx = REQ;
      REQ: begin
        ioctl_rd = 1'b1;
        state_nx = WAIT;
      end
      WAIT: if (bdone) begin
        if (stop_now)                     state_nx = IDLE;
        else if (want || bcnt != 2'd3)    state_nx = REQ;
        else                              state_nx = FILL;
      end
      FILL: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bridge_rd_data <= '0;
      rd_valid       <= 1'b0;
      uploading      <= 1'b0;
      timeout_err    <= 1'b0;
      ftag           <= '0;
      ntag           <= '0;
      tag            <= '0;
      ptag           <= '0;
      bcnt           <= '0;
      cnt            <= '0;
      fword          <= '0;
      wbuf           <= '0;
      valid          <= 1'b0;
      want           <= 1'b0;
      pend           <= 1'b0;
      stop_req       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (want && uploading) begin
          ftag <= ntag;
          bcnt <= '0;
          want <= 1'b0;
        end
        REQ: cnt <= '0;
        WAIT: if (bdone) begin
          fword <= {fword[23:0], ioctl_rdy ? ioctl_din : 8'hFF};
          if (!ioctl_rdy) timeout_err <= 1'b1;
          if (stop_now) begin
            uploading <= 1'b0;
            want      <= 1'b0;
            pend      <= 1'b0;
            stop_req  <= 1'b0;
          end else if (want) begin
            ftag <= ntag;
            bcnt <= '0;
            want <= 1'b0;
          end else begin
            bcnt <= bcnt + 2'd1;
          end
        end else begin
          cnt <= cnt + 8'd1;
        end
        FILL: if (!want) begin
          wbuf  <= fword;
          tag   <= ftag;
          valid <= 1'b1;
          if (pend && ptag == ftag) begin
            bridge_rd_data <= fword;
            rd_valid       <= 1'b1;
            pend           <= 1'b0;
            want           <= 1'b1;
            ntag           <= ftag + TW'(1);
          end
        end
        default: ;
      endcase

      // Session control and bridge requests come last so they override the fetch engine
      if (upload_start) begin
        uploading   <= 1'b1;
        timeout_err <= 1'b0;
        valid       <= 1'b0;
        want        <= 1'b1;
        ntag        <= upload_base[AW-1:2];
        pend        <= 1'b0;
        stop_req    <= 1'b0;
      end else if (upload_stop) begin
        if (state == REQ || (state == WAIT && !bdone)) begin
          stop_req <= 1'b1;
        end else begin
          uploading <= 1'b0;
          want      <= 1'b0;
          pend      <= 1'b0;
        end
      end else if (acc) begin
        if (hit) begin
          bridge_rd_data <= wbuf;
          rd_valid       <= 1'b1;
          pend           <= 1'b0;
          if (!(fetching && target == tag + TW'(1))) begin
            want <= 1'b1;
            ntag <= tag + TW'(1);
          end
        end else if (state == FILL && !want && waddr == ftag) begin
          bridge_rd_data <= fword;
          rd_valid       <= 1'b1;
          pend           <= 1'b0;
          want           <= 1'b1;
          ntag           <= ftag + TW'(1);
        end else if (fetching && target == waddr) begin
          pend <= 1'b1;
          ptag <= waddr;
        end else begin
          pend  <= 1'b1;
          ptag  <= waddr;
          valid <= 1'b0;
          want  <= 1'b1;
          ntag  <= waddr;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_pocket_upload.sv
// Bench for jtframe_pocket_upload: core memory responder, table of bridge reads and
// randomized reads checked against a word-level memory model.
module tb_jtframe_pocket_upload;
  localparam int AW = 25;
  localparam int K_HIT = 0, K_MISS = 1, K_IGN = 2, K_ANY = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          upload_start, upload_stop, bridge_rd;
  logic [AW-1:0] upload_base;
  logic [31:0]   bridge_addr, bridge_rd_data;
  logic          rd_valid, busy, uploading, timeout_err, ioctl_rd, ioctl_rdy;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_din;

  jtframe_pocket_upload #(.AW(AW), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .upload_start(upload_start), .upload_stop(upload_stop),
    .upload_base(upload_base), .bridge_rd(bridge_rd), .bridge_addr(bridge_addr),
    .bridge_rd_data(bridge_rd_data), .rd_valid(rd_valid), .busy(busy),
    .uploading(uploading), .timeout_err(timeout_err), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din), .ioctl_rdy(ioctl_rdy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int lat = 2;                 // core latency in cycles; 0 = never ready
  int unsigned cyc = 0, nrd = 0, nvalid = 0;
  logic [7:0]    mem [0:4095];
  logic [AW-1:0] rd_addrs[$];
  int unsigned   rd_times[$];

  typedef struct {
    logic [31:0] addr;
    int          gap;
    int          kind;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[11];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {mem[b], mem[b + 12'd1], mem[b + 12'd2], mem[b + 12'd3]};
  endfunction

  // Core memory responder: answers each ioctl_rd after 'lat' cycles
  initial begin : core_model
    int          left;
    logic [11:0] pa;
    bit          outstanding;
    left = 0; pa = '0; outstanding = 0;
    ioctl_rdy = 1'b0; ioctl_din = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      ioctl_rdy = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          ioctl_rdy   = 1'b1;
          ioctl_din   = mem[pa];
          outstanding = 0;
        end
      end
      if (ioctl_rd) begin
        nrd++;
        rd_addrs.push_back(ioctl_addr);
        rd_times.push_back(cyc);
        check("ioctl_rd_overlap", 32'(outstanding), 32'd0);
        pa = ioctl_addr[11:0];
        if (lat > 0) begin
          left = lat;
          outstanding = 1;
        end
      end
      if (rd_valid) nvalid++;
    end
  end

  task automatic start_session(input logic [AW-1:0] base);
    upload_base = base; upload_start = 1'b1;
    tick();
    upload_start = 1'b0;
  endtask

  task automatic bridge_read(input string nm, input logic [31:0] a, input int kind,
                             input logic [31:0] exp);
    int unsigned vb, rb;
    bit got;
    vb = nvalid; rb = nrd;
    bridge_addr = a; bridge_rd = 1'b1;
    tick();
    bridge_rd = 1'b0;
    if (kind == K_HIT) begin
      check({nm, " hit rd_valid"}, 32'(rd_valid), 32'd1);
      check({nm, " hit busy"}, 32'(busy), 32'd0);
      check({nm, " hit data"}, bridge_rd_data, exp);
    end else if (kind == K_IGN) begin
      repeat (40) tick();
      check({nm, " ignored rd_valid count"}, nvalid, vb);
      check({nm, " ignored ioctl_rd count"}, nrd, rb);
    end else begin
      if (kind == K_MISS) check({nm, " miss busy"}, 32'(busy), 32'd1);
      got = 0;
      for (int c = 0; c < 300; c++) begin
        if (rd_valid) begin got = 1; break; end
        tick();
      end
      check({nm, " answered"}, 32'(got), 32'd1);
      check({nm, " data"}, bridge_rd_data, exp);
      if (kind == K_MISS) check({nm, " busy after fill"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last, a;
    int          kind;
    bit          longgap;
    int unsigned snap_rd, snap_v;

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    rst_n = 1'b0; upload_start = 1'b0; upload_stop = 1'b0; upload_base = '0;
    bridge_rd = 1'b0; bridge_addr = '0;
    repeat (3) tick();
    check("reset flags", {27'd0, rd_valid, busy, uploading, timeout_err, ioctl_rd}, 32'd0);
    check("reset ioctl_addr", 32'(ioctl_addr), 32'd0);
    check("reset rd_data", bridge_rd_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // Session start fetches bytes 0..3; a hit then prefetches 4..7
    lat = 2;
    rd_addrs.delete();
    start_session('0);
    check("start uploading", 32'(uploading), 32'd1);
    repeat (40) tick();
    check("start fetch count", rd_addrs.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("start fetch addr", 32'(rd_addrs[i]), 32'(i));
    bridge_read("first", 32'h0, K_HIT, 32'h11223344);
    repeat (40) tick();
    check("prefetch count", rd_addrs.size(), 32'd8);
    for (int i = 4; i < 8; i++) check("prefetch addr", 32'(rd_addrs[i]), 32'(i));

    tbl[0]  = '{32'h0000_0004, 30, K_HIT,  32'h0};
    tbl[1]  = '{32'h0000_0008, 30, K_HIT,  32'h0};
    tbl[2]  = '{32'h0000_0100, 30, K_MISS, 32'h0};
    tbl[3]  = '{32'h0000_0104, 30, K_HIT,  32'h0};
    tbl[4]  = '{32'hF800_0104, 30, K_IGN,  32'h0};
    tbl[5]  = '{32'h0000_0104, 30, K_MISS, 32'h0};
    tbl[6]  = '{32'h0000_0108, 30, K_HIT,  32'h0};
    tbl[7]  = '{32'h0000_0108,  0, K_HIT,  32'h0};
    tbl[8]  = '{32'h0000_0FFC, 30, K_MISS, 32'h0};
    tbl[9]  = '{32'h0000_1000, 30, K_HIT,  32'h0};
    tbl[10] = '{32'h0000_0004, 30, K_MISS, 32'h0};
    for (int i = 0; i < 11; i++) tbl[i].exp = mword(tbl[i].addr);
    for (int i = 0; i < 11; i++) begin
      repeat (tbl[i].gap) tick();
      bridge_read($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].kind, tbl[i].exp);
    end

    // Random reads: after answering word W the buffer holds W until the prefetch of W+1 lands
    last = 32'h4;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       a = last + 32'd4;
        1:       a = last;
        default: a = 32'($urandom_range(0, 1023)) * 32'd4;
      endcase
      longgap = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 3);
      repeat (longgap ? 40 : $urandom_range(0, 2)) tick();
      kind = ((longgap && a == last + 32'd4) || (!longgap && a == last)) ? K_HIT : K_ANY;
      bridge_read($sformatf("rand%0d", i), a, kind, mword(a));
      last = a;
    end

    // Core never ready: every byte replaced by FF after the timeout
    repeat (60) tick();
    lat = 0;
    rd_times.delete();
    start_session(25'h200);
    bridge_read("timeout", 32'h200, K_MISS, 32'hFFFF_FFFF);
    check("timeout_err set", 32'(timeout_err), 32'd1);
    check("timeout byte spacing", rd_times[1] - rd_times[0], 32'd17);
    repeat (120) tick();
    check("timeout_err sticky", 32'(timeout_err), 32'd1);
    lat = 2;
    start_session('0);
    check("timeout_err cleared", 32'(timeout_err), 32'd0);
    repeat (30) tick();
    bridge_read("restart", 32'h0, K_HIT, 32'h11223344);

    // Stop ends the session; later reads are ignored
    repeat (30) tick();
    upload_stop = 1'b1;
    tick();
    upload_stop = 1'b0;
    check("stop uploading", 32'(uploading), 32'd0);
    bridge_read("after stop", 32'h4, K_IGN, 32'h0);

    // Reset while a byte is outstanding; its late rdy must be ignored
    lat = 3;
    start_session(25'h300);
    tick(); tick();
    check("pre-reset uploading", 32'(uploading), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset flags", {27'd0, rd_valid, busy, uploading, timeout_err, ioctl_rd}, 32'd0);
    check("async reset ioctl_addr", 32'(ioctl_addr), 32'd0);
    check("async reset rd_data", bridge_rd_data, 32'd0);
    tick();
    rst_n = 1'b1;
    snap_rd = nrd; snap_v = nvalid;
    repeat (30) tick();
    check("post-reset ioctl_rd count", nrd, snap_rd);
    check("post-reset rd_valid count", nvalid, snap_v);
    check("post-reset uploading", 32'(uploading), 32'd0);
    check("post-reset ioctl_addr", 32'(ioctl_addr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
